// File: rtl/memwrite_checker.sv
// memwrite_checker: compares data-memory writes against an ordered expected-write table,
// tolerates a scratch window, and reports a sticky pass/fail verdict with diagnostics.
module memwrite_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [ADDR_W-1:0] ign_base,
    input  logic [ADDR_W-1:0] ign_mask,
    input  logic [IDX_W:0]    num_exp,
    input  logic              start,
    output logic              armed,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W:0]    match_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    // State bits double as the status outputs: [0] armed, [1] done, [2] pass, [3] fail.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0000,
        S_ARMED = 4'b0001,
        S_PASS  = 4'b0110,
        S_FAIL  = 4'b1010
    } state_t;

    typedef enum logic [2:0] {
        F_NONE    = 3'd0,
        F_DATA    = 3'd1,
        F_ADDR    = 3'd2,
        F_TIMEOUT = 3'd3,
        F_CONFIG  = 3'd4
    } fail_code_t;

    state_t            state;
    logic [ADDR_W-1:0] exp_addr [NUM_EXP];
    logic [DATA_W-1:0] exp_data [NUM_EXP];
    logic [IDX_W:0]    num_lat;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W:0]    match_next;
    logic [CNT_W-1:0]  cycle_next;
    logic              addr_hit;
    logic              data_hit;
    logic              in_window;
    logic              timed_out;
    logic              bad_cfg;

    // The match count is also the table pointer: entries are consumed strictly in order.
    assign ptr        = match_cnt[IDX_W-1:0];
    assign addr_hit   = (mem_addr == exp_addr[ptr]);
    assign data_hit   = (mem_wdata == exp_data[ptr]);
    assign in_window  = (ign_mask != '0) && ((mem_addr & ign_mask) == (ign_base & ign_mask));
    assign match_next = match_cnt + (IDX_W+1)'(1);
    assign cycle_next = cycle_cnt + CNT_W'(1);
    assign timed_out  = (cycle_next == CNT_W'(TIMEOUT));
    assign bad_cfg    = (num_exp == '0) || (int'(num_exp) > NUM_EXP);

    assign armed = state[0];
    assign done  = state[1];
    assign pass  = state[2];
    assign fail  = state[3];

    // NOTE: the table is reset so an entry that was never loaded compares as zero, not X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                exp_addr[i] <= '0;
                exp_data[i] <= '0;
            end
        end else if (cfg_we && (state != S_ARMED) && (int'(cfg_idx) < NUM_EXP)) begin
            exp_addr[cfg_idx] <= cfg_addr;
            exp_data[cfg_idx] <= cfg_data;
        end
    end

    // NOTE: every state register here uses <= so all decisions see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            num_lat   <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            fail_code <= F_NONE;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                S_ARMED: begin
                    cycle_cnt <= cycle_next;
                    if (mem_we && addr_hit && data_hit) begin
                        match_cnt <= match_next;
                        if (match_next == num_lat) begin
                            state <= S_PASS;
                        end else if (timed_out) begin
                            state     <= S_FAIL;
                            fail_code <= F_TIMEOUT;
                        end
                    end else if (mem_we && (addr_hit || !in_window)) begin
                        // Expected address takes precedence over the scratch window.
                        state     <= S_FAIL;
                        fail_code <= addr_hit ? F_DATA : F_ADDR;
                        fail_addr <= mem_addr;
                        fail_data <= mem_wdata;
                    end else if (timed_out) begin
                        state     <= S_FAIL;
                        fail_code <= F_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        num_lat   <= num_exp;
                        match_cnt <= '0;
                        cycle_cnt <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        if (bad_cfg) begin
                            state     <= S_FAIL;
                            fail_code <= F_CONFIG;
                        end else begin
                            state     <= S_ARMED;
                            fail_code <= F_NONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memwrite_checker.sv
// Self-checking bench for memwrite_checker: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a behavioural model.
module tb_memwrite_checker;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NE = 4;
    localparam int IW = 2;
    localparam int TO = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [AW-1:0] ign_base = '0;
    logic [AW-1:0] ign_mask = '0;
    logic [IW:0]   num_exp = '0;
    logic          start = 1'b0;
    logic          armed, done, pass, fail;
    logic [2:0]    fail_code;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [IW:0]   match_cnt;
    logic [CW-1:0] cycle_cnt;

    always #5 clk = ~clk;

    memwrite_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_EXP(NE), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .ign_base(ign_base), .ign_mask(ign_mask), .num_exp(num_exp),
        .start(start), .armed(armed), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_addr(fail_addr), .fail_data(fail_data),
        .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: verdict as 0 idle, 1 running, 2 passed, 3 failed.
    int          m_st, m_n, m_match, m_cyc, m_code;
    logic [31:0] m_a [NE];
    logic [31:0] m_d [NE];
    logic [31:0] m_fa, m_fd;

    task automatic model_reset();
        m_st = 0; m_n = 0; m_match = 0; m_cyc = 0; m_code = 0; m_fa = 0; m_fd = 0;
        for (int i = 0; i < NE; i++) begin
            m_a[i] = 0;
            m_d[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit decided;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_st != 1) begin
            if (cfg_we) begin
                m_a[cfg_idx] = cfg_addr;
                m_d[cfg_idx] = cfg_data;
            end
            if (start) begin
                m_n = num_exp; m_match = 0; m_cyc = 0; m_code = 0; m_fa = 0; m_fd = 0;
                if (m_n == 0 || m_n > NE) begin
                    m_st = 3; m_code = 4;
                end else begin
                    m_st = 1;
                end
            end
            return;
        end
        m_cyc++;
        decided = 0;
        if (mem_we) begin
            if (mem_addr == m_a[m_match]) begin
                if (mem_wdata == m_d[m_match]) begin
                    m_match++;
                    if (m_match == m_n) begin
                        m_st = 2; decided = 1;
                    end
                end else begin
                    m_st = 3; m_code = 1; m_fa = mem_addr; m_fd = mem_wdata; decided = 1;
                end
            end else if (ign_mask != 0 && ((mem_addr ^ ign_base) & ign_mask) == 0) begin
                decided = 0;
            end else begin
                m_st = 3; m_code = 2; m_fa = mem_addr; m_fd = mem_wdata; decided = 1;
            end
        end
        if (!decided && m_cyc == TO) begin
            m_st = 3; m_code = 3;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".armed"}, armed, m_st == 1);
        check({tag, ".done"}, done, m_st >= 2);
        check({tag, ".pass"}, pass, m_st == 2);
        check({tag, ".fail"}, fail, m_st == 3);
        check({tag, ".code"}, fail_code, m_code);
        check({tag, ".faddr"}, fail_addr, m_fa);
        check({tag, ".fdata"}, fail_data, m_fd);
        check({tag, ".match"}, match_cnt, m_match);
        check({tag, ".cycles"}, cycle_cnt, m_cyc);
    endtask

    task automatic check_out(input string tag, input logic a, input logic p, input logic f,
                             input logic [2:0] code, input logic [31:0] fa, input logic [31:0] fd,
                             input int mc);
        check({tag, ".armed"}, armed, a);
        check({tag, ".done"}, done, p | f);
        check({tag, ".pass"}, pass, p);
        check({tag, ".fail"}, fail, f);
        check({tag, ".code"}, fail_code, code);
        check({tag, ".faddr"}, fail_addr, fa);
        check({tag, ".fdata"}, fail_data, fd);
        check({tag, ".match"}, match_cnt, mc);
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT; sampling is 1ns after.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        tick();
        mem_we = 1'b0;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input int n);
        start = 1'b1; num_exp = (IW+1)'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1 model_reset();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        e_armed;
        logic        e_pass;
        logic        e_fail;
        logic [2:0]  e_code;
        logic [31:0] e_fa;
        logic [31:0] e_fd;
        int          e_match;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-target configuration: entry0=(84,7), scratch address 80.
        vecs[0] = '{32'd80, 32'd3, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0,  32'd0, 0};
        vecs[1] = '{32'd84, 32'd7, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0,  32'd0, 1};
        vecs[2] = '{32'd84, 32'd6, 1'b0, 1'b0, 1'b1, 3'd1, 32'd84, 32'd6, 0};
        vecs[3] = '{32'd88, 32'd7, 1'b0, 1'b0, 1'b1, 3'd2, 32'd88, 32'd7, 0};
        vecs[4] = '{32'd80, 32'd9, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0,  32'd0, 0};
        vecs[5] = '{32'd81, 32'd7, 1'b0, 1'b0, 1'b1, 3'd2, 32'd81, 32'd7, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0);
        check("reset.cycles", cycle_cnt, 0);
        reset = 1'b1;
        tick();

        ign_base = 32'd80; ign_mask = 32'hFFFF_FFFF;
        foreach (vecs[i]) begin
            reset_pulse();
            load(0, 32'd84, 32'd7);
            arm(1);
            wr(vecs[i].addr, vecs[i].data);
            check_out($sformatf("vec%0d", i), vecs[i].e_armed, vecs[i].e_pass, vecs[i].e_fail,
                      vecs[i].e_code, vecs[i].e_fa, vecs[i].e_fd, vecs[i].e_match);
        end

        // Scratch writes tolerated, then the expected write passes.
        reset_pulse();
        load(0, 32'd84, 32'd7);
        arm(1);
        check("arm.armed", armed, 1'b1);
        wr(32'd80, 32'd3);
        wr(32'd80, 32'd9);
        check("scratch.done", done, 1'b0);
        wr(32'd84, 32'd7);
        check_out("seq_pass", 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1);
        wr(32'd99, 32'd1);
        check("pass_hold.pass", pass, 1'b1);

        // Unexpected address, then a restart clears the failure.
        arm(1);
        wr(32'd88, 32'd7);
        check_out("addr_fail", 1'b0, 1'b0, 1'b1, 3'd2, 32'd88, 32'd7, 0);
        arm(1);
        check_out("restart", 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0);
        wr(32'd84, 32'd7);
        check_out("restart_pass", 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1);

        // Timeout lands exactly TO cycles after arming; counter then freezes.
        arm(1);
        repeat (TO - 1) tick();
        check("to_pre.armed", armed, 1'b1);
        check("to_pre.cycles", cycle_cnt, TO - 1);
        tick();
        check_out("timeout", 1'b0, 1'b0, 1'b1, 3'd3, 32'd0, 32'd0, 0);
        check("timeout.cycles", cycle_cnt, TO);
        tick();
        check("frozen.cycles", cycle_cnt, TO);

        // Last match on the timeout edge wins.
        arm(1);
        repeat (TO - 1) tick();
        wr(32'd84, 32'd7);
        check_out("late_pass", 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1);
        check("late_pass.cycles", cycle_cnt, TO);

        // Three-entry ordered sequence, window disabled.
        ign_mask = 32'h0;
        load(0, 32'h10, 32'd1);
        load(1, 32'h14, 32'd2);
        load(2, 32'h18, 32'd3);
        arm(3);
        wr(32'h14, 32'd2);
        check_out("order_fail", 1'b0, 1'b0, 1'b1, 3'd2, 32'h14, 32'd2, 0);
        arm(3);
        wr(32'h10, 32'd1);
        wr(32'h14, 32'd2);
        check("mid.armed", armed, 1'b1);
        arm(1);
        check("start_ignored.match", match_cnt, 2);
        wr(32'h18, 32'd3);
        check_out("order_pass", 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 3);
        arm(0);
        check_out("cfg0", 1'b0, 1'b0, 1'b1, 3'd4, 32'd0, 32'd0, 0);
        arm(5);
        check_out("cfg5", 1'b0, 1'b0, 1'b1, 3'd4, 32'd0, 32'd0, 0);

        // Expected address inside the window is still matched and data-checked.
        ign_base = 32'h10; ign_mask = 32'hFFFF_FFF0;
        arm(3);
        wr(32'h1C, 32'd9);
        check("win_ign.armed", armed, 1'b1);
        wr(32'h10, 32'd1);
        check("win_match", match_cnt, 1);
        wr(32'h14, 32'd5);
        check_out("win_data", 1'b0, 1'b0, 1'b1, 3'd1, 32'h14, 32'd5, 1);

        // Config writes are locked out while running; async reset clears everything.
        arm(3);
        load(0, 32'h99, 32'd9);
        wr(32'h10, 32'd1);
        check("cfg_locked.match", match_cnt, 1);
        #2 reset = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0);
        check("async_rst.cycles", cycle_cnt, 0);
        model_reset();
        reset = 1'b1;
        ign_mask = 32'h0;
        arm(1);
        wr(32'h0, 32'h0);
        check("table_cleared.pass", pass, 1'b1);

        // Randomized traffic against the model.
        for (int r = 0; r < 30; r++) begin
            reset_pulse();
            ign_base = 32'h10 + 32'($urandom_range(0, 7)) * 4;
            case ($urandom_range(0, 3))
                0: ign_mask = 32'h0;
                1: ign_mask = 32'hFFFF_FFFF;
                2: ign_mask = 32'hFFFF_FFF8;
                default: ign_mask = 32'hFFFF_FFF0;
            endcase
            for (int k = 0; k < NE; k++)
                load(k, 32'h10 + 32'($urandom_range(0, 3)) * 4, 32'($urandom_range(0, 3)));
            arm($urandom_range(0, 5));
            check_model("rnd_arm");
            for (int c = 0; c < 30; c++) begin
                mem_we = ($urandom_range(0, 3) != 0);
                if (m_st == 1 && $urandom_range(0, 1) == 1) begin
                    mem_addr  = m_a[m_match];
                    mem_wdata = ($urandom_range(0, 7) == 0) ? (m_d[m_match] ^ 32'd1) : m_d[m_match];
                end else begin
                    mem_addr  = 32'h10 + 32'($urandom_range(0, 7)) * 4;
                    mem_wdata = 32'($urandom_range(0, 3));
                end
                start    = ($urandom_range(0, 15) == 0);
                num_exp  = (IW+1)'($urandom_range(1, 4));
                cfg_we   = ($urandom_range(0, 7) == 0);
                cfg_idx  = IW'($urandom_range(0, 3));
                cfg_addr = 32'h10 + 32'($urandom_range(0, 3)) * 4;
                cfg_data = 32'($urandom_range(0, 3));
                tick();
                check_model($sformatf("rnd%0d_%0d", r, c));
            end
            mem_we = 1'b0; start = 1'b0; cfg_we = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memwrite_checker.md
# memwrite_checker

Synthesizable, parametrised memory-write checker that sits beside the processor's data-memory port and decides test pass/fail in hardware. It watches every `mem_we` cycle, requires an ordered sequence of up to `NUM_EXP` expected (address, data) writes, tolerates writes into a programmable scratch window, and flags any other write or a timeout as a failure with a code and the offending address/data. It generalises the single-target bench check (success on address 84 / data 7, tolerate address 80) into a reusable block for simulation and FPGA self-test.

## Interface

- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NUM_EXP`, 4, depth of the expected-write table (≥1)
- `IDX_W`, $clog2(NUM_EXP) (min 1), table index width
- `TIMEOUT`, 1024, cycles allowed after arming before timeout fail (≥1)
- `CNT_W`, $clog2(TIMEOUT+1), cycle counter width

- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `mem_we`  in  1  processor data-memory write strobe
- `mem_addr`  in  ADDR_W  write address
- `mem_wdata`  in  DATA_W  write data
- `cfg_we`  in  1  write one table entry
- `cfg_idx`  in  IDX_W  entry index
- `cfg_addr`  in  ADDR_W  expected address for entry
- `cfg_data`  in  DATA_W  expected data for entry
- `ign_base`  in  ADDR_W  scratch-window base
- `ign_mask`  in  ADDR_W  scratch-window compare mask (0 = window disabled)
- `num_exp`  in  IDX_W+1  number of entries to require, sampled at `start`
- `start`  in  1  one-cycle pulse: arm the checker
- `armed`  out  1  checker is running
- `done`  out  1  sticky: verdict reached
- `pass`  out  1  sticky: all expected writes seen
- `fail`  out  1  sticky: failure
- `fail_code`  out  3  0 none, 1 data mismatch, 2 unexpected address, 3 timeout, 4 bad config
- `fail_addr`  out  ADDR_W  address of failing write (0 for codes 3, 4)
- `fail_data`  out  DATA_W  data of failing write (0 for codes 3, 4)
- `match_cnt`  out  IDX_W+1  expected writes matched so far
- `cycle_cnt`  out  CNT_W  cycles since arming, saturating at TIMEOUT

## Operation

- States: IDLE, ARMED, PASS, FAIL. `armed` = ARMED; `done` = PASS|FAIL; `pass` = PASS; `fail` = FAIL.
- Reset (`reset`=0): state IDLE, every output 0, table entries 0, pointer 0, latched `num_exp` 0.
- `cfg_we` writes entry `cfg_idx` in IDLE, PASS, FAIL; ignored in ARMED. `cfg_idx` ≥ NUM_EXP ignored.
- `start` in any state except ARMED: latch `num_exp`; clear pointer, `match_cnt`, `cycle_cnt`, `fail_code`, `fail_addr`, `fail_data`. If latched value is 0 or > NUM_EXP go to FAIL code 4; else ARMED. `start` in ARMED ignored.
- ARMED, each edge: `cycle_cnt` increments. If `mem_we`=1, evaluate in priority order against entry[ptr]:
  1. `mem_addr`==addr[ptr] and `mem_wdata`==data[ptr]: ptr++, `match_cnt`++; if new `match_cnt`==num_exp go to PASS.
  2. `mem_addr`==addr[ptr], data differs: FAIL code 1.
  3. `(mem_addr & ign_mask)==(ign_base & ign_mask)` with `ign_mask`≠0: ignored.
  4. otherwise: FAIL code 2; latch `mem_addr`, `mem_wdata` into `fail_addr`/`fail_data` (also for code 1).
- Timeout: in ARMED, if the incremented `cycle_cnt` equals TIMEOUT and the same-cycle write did not produce PASS or FAIL, go to FAIL code 3.
- PASS/FAIL hold until `start` or reset; `mem_we` ignored there; `cycle_cnt` frozen.
- Expected-match check precedes window check: an expected address inside the scratch window still counts.

## Timing

- All outputs registered; verdict visible the cycle after the deciding edge.
- `start` at edge N → `armed`=1 after edge N; first write evaluated at edge N+1.
- Write at edge N completing sequence → `done`=`pass`=1 after edge N.
- Timeout: no verdict, armed at edge N → FAIL after edge N+TIMEOUT.
- Simultaneous last match and timeout edge → PASS.
- Asynchronous reset mid-run: outputs 0 immediately, no waiting for clock.

## Test plan

- Load entry0=(84,7), num_exp=1, ign_base=80, ign_mask=0xFFFFFFFF, start; writes (80,3),(80,9),(84,7) → PASS after third write, match_cnt=1, fail_code=0.
- Same config; write (84,6) → FAIL code 1, fail_addr=84, fail_data=6.
- Same config; write (88,7) → FAIL code 2, fail_addr=88; then start, write (84,7) → PASS, old failure cleared.
- TIMEOUT=16, no writes after start → FAIL code 3 exactly 16 cycles after arming; cycle_cnt=16; last-match write on the 16th cycle instead → PASS.
- num_exp=3 with entries (0x10,1),(0x14,2),(0x18,3); out-of-order write (0x14,2) first → FAIL code 2; in-order → PASS, match_cnt=3; num_exp=0 → FAIL code 4.
- Deassert `reset` mid-ARMED between edges → all outputs 0 immediately; cfg_we during ARMED leaves table unchanged.
